// File: rtl/fifo_load_scheduler_pkg.sv
// fifo_load_scheduler_pkg: shared state/owner encodings and default sizing for the load scheduler
package fifo_load_scheduler_pkg;
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_RUN        = 3'd3,
    S_ACK        = 3'd4,
    S_ERROR      = 3'd5
  } state_t;
  localparam logic OWN_WT = 1'b0;
  localparam logic OWN_IN = 1'b1;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_TIMEOUT_SLACK = 8;
endpackage

// File: rtl/fifo_load_scheduler.sv
// fifo_load_scheduler: arbitrates weight loads and input feeds onto one FIFO-load engine with a hang watchdog
module fifo_load_scheduler
  import fifo_load_scheduler_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int TIMEOUT_SLACK = DEF_TIMEOUT_SLACK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wt_req,
  input  logic       in_req,
  input  logic       err_clr,
  input  logic       ctl_done,
  output logic       ctl_active,
  output logic       ctl_stagger,
  output logic       wt_ack,
  output logic       in_ack,
  output logic       busy,
  output logic       weights_valid,
  output logic [7:0] feed_count,
  output logic       error
);
  localparam int WD_LIMIT = 2 * FIFO_WIDTH + TIMEOUT_SLACK;
  localparam int WD_W = $clog2(WD_LIMIT) + 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic ctl_active_q, ctl_active_d, ctl_stagger_q, ctl_stagger_d;
  logic wt_ack_q, wt_ack_d, in_ack_q, in_ack_d, busy_q, busy_d;
  logic weights_valid_q, weights_valid_d, error_q, error_d;
  logic [7:0] feed_count_q, feed_count_d;
  logic in_ok, grant, grant_own;
  assign in_ok = in_req && weights_valid_q;
  assign grant = ctl_done && (wt_req || in_ok);
  assign grant_own = (wt_req && in_ok) ? ~last_q : (in_ok ? OWN_IN : OWN_WT);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    wd_d = wd_q;
    ctl_active_d = 1'b0;
    ctl_stagger_d = 1'b0;
    wt_ack_d = 1'b0;
    in_ack_d = 1'b0;
    weights_valid_d = weights_valid_q;
    feed_count_d = feed_count_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: if (grant) begin
        state_d = S_ISSUE;
        owner_d = grant_own;
        last_d = grant_own;
        ctl_active_d = 1'b1;
        ctl_stagger_d = grant_own == OWN_IN;
        if (grant_own == OWN_WT) begin
          weights_valid_d = 1'b0;
          feed_count_d = 8'd0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_START;
        wd_d = '0;
      end
      S_WAIT_START, S_RUN: begin
        wd_d = wd_q + WD_W'(1);
        if (state_q == S_RUN && ctl_done) begin
          state_d = S_ACK;
          wt_ack_d = owner_q == OWN_WT;
          in_ack_d = owner_q == OWN_IN;
        end else if (wd_d == WD_MAX) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          weights_valid_d = 1'b0;
        end else if (state_q == S_WAIT_START && !ctl_done) begin
          state_d = S_RUN;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        weights_valid_d = (owner_q == OWN_WT) ? 1'b1 : weights_valid_q;
        feed_count_d = (owner_q == OWN_IN && feed_count_q != 8'hFF) ? feed_count_q + 8'd1 : feed_count_q;
      end
      S_ERROR: if (err_clr) begin
        state_d = S_IDLE;
        error_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_WT;
      last_q <= OWN_IN;
      wd_q <= '0;
      ctl_active_q <= 1'b0;
      ctl_stagger_q <= 1'b0;
      wt_ack_q <= 1'b0;
      in_ack_q <= 1'b0;
      busy_q <= 1'b0;
      weights_valid_q <= 1'b0;
      feed_count_q <= 8'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      wd_q <= wd_d;
      ctl_active_q <= ctl_active_d;
      ctl_stagger_q <= ctl_stagger_d;
      wt_ack_q <= wt_ack_d;
      in_ack_q <= in_ack_d;
      busy_q <= busy_d;
      weights_valid_q <= weights_valid_d;
      feed_count_q <= feed_count_d;
      error_q <= error_d;
    end
  assign ctl_active = ctl_active_q;
  assign ctl_stagger = ctl_stagger_q;
  assign wt_ack = wt_ack_q;
  assign in_ack = in_ack_q;
  assign busy = busy_q;
  assign weights_valid = weights_valid_q;
  assign feed_count = feed_count_q;
  assign error = error_q;
endmodule

// File: tb/tb_fifo_load_scheduler.sv
// tb_fifo_load_scheduler: directed scoreboard bench for fifo_load_scheduler with a behavioural engine model
module tb_fifo_load_scheduler;
  import fifo_load_scheduler_pkg::*;
  localparam int FW = DEF_FIFO_WIDTH;
  typedef struct {
    logic own;
    int lat;
  } ev_t;
  logic clk, reset, wt_req, in_req, err_clr, ctl_done;
  logic ctl_active, ctl_stagger, wt_ack, in_ack, busy, weights_valid, error;
  logic [7:0] feed_count;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int act_cyc = 0;
  int n_act = 0;
  int n_ack = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic eng_done = 1'b1;
  int eng_cnt = 0;
  logic eng_hang = 1'b0;
  logic eng_release = 1'b0;
  logic hold_busy = 1'b0;
  fifo_load_scheduler dut (
    .clk(clk), .reset(reset), .wt_req(wt_req), .in_req(in_req), .err_clr(err_clr),
    .ctl_done(ctl_done), .ctl_active(ctl_active), .ctl_stagger(ctl_stagger),
    .wt_ack(wt_ack), .in_ack(in_ack), .busy(busy), .weights_valid(weights_valid),
    .feed_count(feed_count), .error(error)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ctl_done = eng_done && !hold_busy;
  always @(posedge clk)
    if (ctl_active) begin
      eng_done <= 1'b0;
      eng_cnt <= eng_hang ? 0 : (ctl_stagger ? 2 * FW : FW);
    end else if (eng_release) begin
      eng_done <= 1'b1;
    end else if (eng_cnt == 1) begin
      eng_cnt <= 0;
      eng_done <= 1'b1;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end
  always @(negedge clk) begin
    if (ctl_active) begin
      act_cyc <= cyc;
      n_act <= n_act + 1;
    end
    if (wt_ack || in_ack) begin
      obs_q.push_back('{in_ack, cyc - act_cyc});
      n_ack <= n_ack + 1;
    end
  end
  function automatic logic [31:0] outs();
    return {17'd0, ctl_active, ctl_stagger, wt_ack, in_ack, busy, weights_valid, feed_count, error};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_ack(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 100 && at < 0; i++) begin
      @(negedge clk);
      if (wt_ack || in_ack) at = cyc;
    end
    chk({tag, "_seen"}, 32'(wt_ack || in_ack), 1);
  endtask
  task automatic wait_act(input string tag, output int at, output logic stg);
    at = -1;
    stg = 1'b0;
    for (int i = 0; i < 100 && at < 0; i++) begin
      @(negedge clk);
      if (ctl_active) begin
        at = cyc;
        stg = ctl_stagger;
      end
    end
    chk({tag, "_seen"}, 32'(ctl_active), 1);
  endtask
  task automatic push(input logic own);
    exp_q.push_back('{own, own == OWN_IN ? 2 * FW + 2 : FW + 2});
  endtask
  task automatic drain(input string tag);
    ev_t o, e;
    chk({tag, "_sb_n"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_sb_own"}, 32'(o.own), 32'(e.own));
      chk({tag, "_sb_lat"}, o.lat, e.lat);
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int t, a, a2, c, e, n0, k;
    logic s;
    reset = 1'b1;
    wt_req = 1'b0;
    in_req = 1'b0;
    err_clr = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    reset = 1'b1;
    @(negedge clk);
    wt_req = 1'b1;
    t = cyc + 1;
    push(OWN_WT);
    @(negedge clk);
    chk("t1_active", 32'(ctl_active), 1);
    chk("t1_stagger", 32'(ctl_stagger), 0);
    chk("t1_busy", 32'(busy), 1);
    wait_ack("t1_ack", a);
    wt_req = 1'b0;
    chk("t1_ack_cycle", a, t + FW + 2);
    chk("t1_wt_ack", 32'(wt_ack), 1);
    chk("t1_wv_during", 32'(weights_valid), 0);
    @(negedge clk);
    chk("t1_wv_after", 32'(weights_valid), 1);
    chk("t1_idle", 32'(busy), 0);
    drain("t1");
    wt_req = 1'b1;
    repeat (8) @(negedge clk);
    chk("t2_busy", 32'(busy), 1);
    n0 = n_ack;
    reset = 1'b0;
    #1;
    chk("t2_async_outs", outs(), 0);
    wt_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("t2_no_ack", n_ack, n0);
    chk("t2_idle", 32'(busy), 0);
    drain("t2");
    in_req = 1'b1;
    n0 = n_act;
    repeat (50) @(negedge clk);
    chk("t3_no_grant", n_act, n0);
    wt_req = 1'b1;
    push(OWN_WT);
    push(OWN_IN);
    wait_ack("t3_wt", a);
    wt_req = 1'b0;
    chk("t3_wt_ack", 32'(wt_ack), 1);
    wait_act("t3_in_act", c, s);
    chk("t3_stagger", 32'(s), 1);
    chk("t3_grant_cycle", c, a + 2);
    wait_ack("t3_in", a2);
    in_req = 1'b0;
    chk("t3_in_ack", 32'(in_ack), 1);
    chk("t3_in_lat", a2, c + 2 * FW + 2);
    @(negedge clk);
    chk("t3_fc", 32'(feed_count), 1);
    drain("t3");
    wt_req = 1'b1;
    in_req = 1'b1;
    push(OWN_WT);
    push(OWN_IN);
    push(OWN_WT);
    push(OWN_IN);
    wait_act("t4_g0", c, s);
    chk("t4_g0_stagger", 32'(s), 0);
    chk("t4_g0_fc", 32'(feed_count), 0);
    chk("t4_g0_wv", 32'(weights_valid), 0);
    wait_ack("t4_a0", a);
    wait_act("t4_g1", c, s);
    chk("t4_g1_stagger", 32'(s), 1);
    wait_ack("t4_a1", a);
    @(negedge clk);
    chk("t4_fc1", 32'(feed_count), 1);
    wait_act("t4_g2", c, s);
    chk("t4_g2_stagger", 32'(s), 0);
    chk("t4_g2_fc", 32'(feed_count), 0);
    chk("t4_g2_wv", 32'(weights_valid), 0);
    wait_ack("t4_a2", a);
    wait_act("t4_g3", c, s);
    chk("t4_g3_stagger", 32'(s), 1);
    wait_ack("t4_a3", a);
    wt_req = 1'b0;
    in_req = 1'b0;
    @(negedge clk);
    chk("t4_fc_end", 32'(feed_count), 1);
    drain("t4");
    eng_hang = 1'b1;
    wt_req = 1'b1;
    wait_act("t5_act", c, s);
    n0 = n_ack;
    e = -1;
    for (int i = 0; i < 60 && e < 0; i++) begin
      @(negedge clk);
      if (error) e = cyc;
    end
    chk("t5_err_cycle", e, c + 2 * FW + DEF_TIMEOUT_SLACK + 1);
    chk("t5_err", 32'(error), 1);
    chk("t5_wv", 32'(weights_valid), 0);
    chk("t5_no_ack", n_ack, n0);
    in_req = 1'b1;
    eng_hang = 1'b0;
    eng_release = 1'b1;
    @(negedge clk);
    eng_release = 1'b0;
    n0 = n_act;
    repeat (10) @(negedge clk);
    chk("t5_no_grant", n_act, n0);
    chk("t5_err_held", 32'(error), 1);
    chk("t5_busy", 32'(busy), 1);
    wt_req = 1'b0;
    in_req = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_err_clr", 32'(error), 0);
    chk("t5_idle", 32'(busy), 0);
    drain("t5");
    hold_busy = 1'b1;
    wt_req = 1'b1;
    n0 = n_act;
    repeat (10) @(negedge clk);
    chk("t6_hold", n_act, n0);
    k = cyc;
    hold_busy = 1'b0;
    push(OWN_WT);
    wait_act("t6_act", c, s);
    chk("t6_act_cycle", c, k + 1);
    wait_ack("t6_wt", a);
    wt_req = 1'b0;
    in_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push(OWN_IN);
      wait_ack("t6_feed", a);
      if (i == 299) in_req = 1'b0;
      if (i == 253 || i == 254 || i == 299) begin
        @(negedge clk);
        chk("t6_fc", 32'(feed_count), i == 253 ? 254 : 255);
      end
    end
    drain("t6");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
